// File: rtl/nibble_serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_addsub_pkg
// Shared definitions for the nibble-serial adder/subtractor:
//   - state_e    : controller states (IDLE / RUN / DONE)
//   - NIBBLE_W   : width of one arithmetic slice
//   - signed_ovf : two's-complement overflow rule for the final slice
// -----------------------------------------------------------------------------
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Overflow occurs when both addends (a and the possibly inverted b) share
    // a sign and the result sign differs from it.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic l_msb,
        input logic sum_msb
    );
        return (a_msb == l_msb) && (sum_msb != a_msb);
    endfunction

endpackage : nibble_serial_addsub_pkg

// File: rtl/addsub_nibble.sv
// -----------------------------------------------------------------------------
// addsub_nibble
// One 4-bit add/subtract slice, purely combinational.
// Subtraction is done as a + ~b + cin, with the caller supplying cin=1 on the
// least significant slice.
// Ports:
//   i_a    [3:0] : operand A nibble
//   i_b    [3:0] : operand B nibble (inverted internally when i_sel=1)
//   i_sel        : 0 = add, 1 = subtract
//   i_cin        : carry in
//   o_sum  [3:0] : sum nibble
//   o_cout       : carry out
// -----------------------------------------------------------------------------
module addsub_nibble
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_sel,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W-1:0] w_l;
    logic [NIBBLE_W:0]   w_full;

    assign w_l    = i_b ^ {NIBBLE_W{i_sel}};
    assign w_full = {1'b0, i_a} + {1'b0, w_l} + {{NIBBLE_W{1'b0}}, i_cin};
    assign o_sum  = w_full[NIBBLE_W-1:0];
    assign o_cout = w_full[NIBBLE_W];

endmodule : addsub_nibble

// File: rtl/nibble_serial_addsub.sv
// -----------------------------------------------------------------------------
// nibble_serial_addsub
// Serial W-bit adder/subtractor that processes one 4-bit slice per clock,
// least significant slice first. An operation accepted at edge 0 produces a
// one-cycle done pulse from edge NIBBLES to edge NIBBLES+1.
// Parameters:
//   NIBBLES : number of 4-bit slices per operand (W = 4*NIBBLES)
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request an operation, sampled only while busy=0
//   sel          : 0 = a+b, 1 = a-b
//   a, b   [W]   : operands, captured on the accepting edge
//   busy         : operation in progress (RUN or DONE)
//   done         : one-cycle result-valid pulse
//   dout   [W]   : result, held until the next accepted start
//   carry_borrow : final carry out (subtract: 1 = no borrow)
//   ovf          : signed overflow of the W-bit result
// -----------------------------------------------------------------------------
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sel,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] dout,
    output logic                      carry_borrow,
    output logic                      ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Controller state and registered status outputs
    state_e                           r_state;
    state_e                           w_state_nxt;
    logic                             r_busy;
    logic                             r_done;
    logic                             w_busy_nxt;
    logic                             w_done_nxt;

    // Operand latches, result and slice bookkeeping (slice-indexed views)
    logic [NIBBLES-1:0][NIBBLE_W-1:0] r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] r_dout;
    logic                             r_sel;
    logic                             r_carry;
    logic [IDX_W-1:0]                 r_idx;
    logic                             r_cb;
    logic                             r_ovf;

    // Slice datapath
    logic [NIBBLE_W-1:0]              w_a_nib;
    logic [NIBBLE_W-1:0]              w_b_nib;
    logic [NIBBLE_W-1:0]              w_sum;
    logic                             w_cin;
    logic                             w_cout;
    logic                             w_l_msb;
    logic                             w_accept;
    logic                             w_step;
    logic                             w_last;

    // Control qualifiers
    assign w_accept = (r_state == IDLE) && start;
    assign w_step   = (r_state == RUN);
    assign w_last   = (r_idx == LAST_IDX);

    // Current slice operands; the first slice takes sel as carry-in so that
    // subtraction becomes a + ~b + 1.
    assign w_a_nib = r_a[r_idx];
    assign w_b_nib = r_b[r_idx];
    assign w_cin   = (r_idx == {IDX_W{1'b0}}) ? r_sel : r_carry;
    assign w_l_msb = w_b_nib[NIBBLE_W-1] ^ r_sel;

    addsub_nibble u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_sel  (r_sel),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register with registered busy/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so busy/done come straight from flops
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            IDLE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
            RUN: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b0;
            end
            DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Operand capture and per-slice result/carry update; dout slices are
    // overwritten only as they are computed, never cleared on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
            r_carry <= 1'b0;
            r_dout  <= '0;
            r_cb    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sel <= sel;
            r_idx <= {IDX_W{1'b0}};
        end else if (w_step) begin
            r_dout[r_idx] <= w_sum;
            r_carry       <= w_cout;
            if (w_last) begin
                r_idx <= {IDX_W{1'b0}};
                r_cb  <= w_cout;
                r_ovf <= signed_ovf(w_a_nib[NIBBLE_W-1], w_l_msb, w_sum[NIBBLE_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign dout         = W'(r_dout);
    assign carry_borrow = r_cb;
    assign ovf          = r_ovf;

endmodule : nibble_serial_addsub

// File: tb/tb_nibble_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_addsub
// Self-checking bench for nibble_serial_addsub with NIBBLES=4 (W=16).
// -----------------------------------------------------------------------------
module tb_nibble_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         cb;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic         sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_dout;
        logic         exp_cb;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[5];

    nibble_serial_addsub #(.NIBBLES(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sel          (sel),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .dout         (dout),
        .carry_borrow (cb),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int r;
        logic [W-1:0] d;
        logic c;
        logic o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r = sx - sy;
            d = x - y;
            c = (x >= y);
        end else begin
            r = sx + sy;
            d = x + y;
            c = ((32'(x) + 32'(y)) > 32'h0000_FFFF);
        end
        o = (r > 32767) || (r < -32768);
        return {c, o, d};
    endfunction

    // Launch one operation, scramble inputs after accept, wait for done.
    task automatic do_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] d, output logic c, output logic o, output int lat);
        @(negedge clk);
        start = 1'b1; sel = s; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
        lat = 0;
        while (!done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", 32'(done), 32'd1);
        d = dout; c = cb; o = ovf;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("dout_held", 32'(dout), 32'(d));
    endtask

    initial begin
        logic [W-1:0] d;
        logic         c;
        logic         o;
        int           lat;
        logic [W+1:0] m;
        int           ndone;
        logic [W-1:0] first_dout;

        vecs[0] = '{"add_1234_0fff", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{"add_ffff_0001", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"add_7fff_0001", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub_0005_0007", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_8000_0001", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_cb",   32'(cb),   32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, d, c, o, lat);
            chk({vecs[i].name, "_dout"}, 32'(d), 32'(vecs[i].exp_dout));
            chk({vecs[i].name, "_cb"},   32'(c), 32'(vecs[i].exp_cb));
            chk({vecs[i].name, "_ovf"},  32'(o), 32'(vecs[i].exp_ovf));
            chk({vecs[i].name, "_lat"},  32'(lat), 32'(N));
        end

        // Start pulses in the 2nd RUN cycle and in DONE are ignored
        @(negedge clk);
        start = 1'b1; sel = 1'b0; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first_dout = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 0) begin
                start = 1'b1; sel = 1'b1; a = 16'hAAAA; b = 16'h5555;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) first_dout = dout;
                start = 1'b1; sel = 1'b1; a = 16'h0F0F; b = 16'h0101;
            end
        end
        start = 1'b0;
        chk("ignore_ndone", 32'(ndone), 32'd1);
        chk("ignore_first_dout", 32'(first_dout), 32'h0000_3333);
        chk("ignore_dout_kept", 32'(dout), 32'h0000_3333);
        chk("ignore_busy", 32'(busy), 32'd0);

        // Asynchronous reset during the 3rd RUN cycle
        @(negedge clk);
        start = 1'b1; sel = 1'b0; a = 16'hFFFF; b = 16'h7FFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_cb",   32'(cb),   32'd0);
        chk("arst_ovf",  32'(ovf),  32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        do_op(1'b0, 16'h0001, 16'h0001, d, c, o, lat);
        chk("post_rst_dout", 32'(d), 32'h0000_0002);
        chk("post_rst_cb",   32'(c), 32'd0);
        chk("post_rst_ovf",  32'(o), 32'd0);
        chk("post_rst_lat",  32'(lat), 32'(N));

        // Randomized operations against the integer model
        for (int i = 0; i < 40; i++) begin
            logic         s;
            logic [W-1:0] x;
            logic [W-1:0] y;
            s = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            if (i % 8 == 0) x = 16'h8000;
            if (i % 8 == 1) y = 16'h8000;
            if (i % 8 == 2) y = x;
            m = model(s, x, y);
            do_op(s, x, y, d, c, o, lat);
            chk("rand_dout", 32'(d), 32'(m[W-1:0]));
            chk("rand_ovf",  32'(o), 32'(m[W]));
            chk("rand_cb",   32'(c), 32'(m[W+1]));
            chk("rand_lat",  32'(lat), 32'(N));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nibble_serial_addsub
